// File: rtl/aes_key_expand.sv
// AES-128 key schedule: presents round keys 0..10 one per ready/valid handshake,
// computing each next key in a single cycle through a shared 4-byte S-box.
module aes_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         key_ready,
    output logic         round_key_valid,
    output logic [3:0]   round,
    output logic [127:0] round_key,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] msb;
        msb = 11'd2047 - {x, 3'b000};
        return SBOX[msb -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    state_t       state, state_nxt;
    logic [7:0]   rcon, rcon_nxt;
    logic [3:0]   round_nxt;
    logic [127:0] key_nxt;
    logic [31:0]  w0, w1, w2, w3, rot, t;
    logic [31:0]  n0, n1, n2, n3;

    assign w0  = round_key[127:96];
    assign w1  = round_key[95:64];
    assign w2  = round_key[63:32];
    assign w3  = round_key[31:0];
    assign rot = {w3[23:0], w3[31:24]};
    assign t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                 ^ {rcon, 24'h000000};
    assign n0  = w0 ^ t;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;

    always_comb begin
        state_nxt = state;
        key_nxt   = round_key;
        round_nxt = round;
        rcon_nxt  = rcon;
        case (state)
            IDLE: begin
                if (start) begin
                    key_nxt   = key_in;
                    round_nxt = '0;
                    rcon_nxt  = 8'h01;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (key_ready) begin
                    if (round != 4'd10) begin
                        key_nxt   = {n0, n1, n2, n3};
                        round_nxt = round + 4'd1;
                        rcon_nxt  = xtime(rcon);
                    end else begin
                        state_nxt = FIN;
                    end
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are flopped from the next state so none depends on key_ready combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            round_key       <= '0;
            round           <= '0;
            rcon            <= 8'h01;
            round_key_valid <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state           <= state_nxt;
            round_key       <= key_nxt;
            round           <= round_nxt;
            rcon            <= rcon_nxt;
            round_key_valid <= (state_nxt == EMIT);
            busy            <= (state_nxt == EMIT);
            done            <= (state_nxt == FIN);
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 and all-zero key schedules,
// back-pressure, ignored starts, and asynchronous reset.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         key_ready;
    logic         round_key_valid;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;

    logic [127:0] fips_rk [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic [127:0] zero_rk [0:10] = '{
        128'h00000000000000000000000000000000,
        128'h62636363626363636263636362636363,
        128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
        128'h90973450696ccffaf2f457330b0fac99,
        128'hee06da7b876a1581759e42b27e91ee2b,
        128'h7f2e2b88f8443e098dda7cbbf34b9290,
        128'hec614b851425758c99ff09376ab49ba7,
        128'h217517873550620bacaf6b3cc61bf09b,
        128'h0ef903333ba9613897060a04511dfa9f,
        128'hb1d4d8e28a7db9da1d7bb3de4c664941,
        128'hb4ef5bcb3e92e21123e951cf6f8f188e
    };

    aes_key_expand dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .key_in         (key_in),
        .key_ready      (key_ready),
        .round_key_valid(round_key_valid),
        .round          (round),
        .round_key      (round_key),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns at the negedge right after the accepting edge; key_in is then scrambled.
    task automatic do_start(input logic [127:0] k);
        @(negedge clk);
        start  = 1'b1;
        key_in = k;
        @(negedge clk);
        start  = 1'b0;
        key_in = ~k;
    endtask

    // Walks one expansion from round 0 to the done pulse, ending in the FIN cycle.
    task automatic expand(input bit use_zero, input bit stall, input bit inject);
        int er = 0;
        int idx = 0;
        int stalls = 0;
        bit fin_due = 1'b0;
        bit finished = 1'b0;
        logic [127:0] exp;
        while (!finished && idx < 200) begin
            exp = use_zero ? zero_rk[er] : fips_rk[er];
            if (fin_due) begin
                check("done_pulse", 128'(done), 128'd1);
                check("done_time", 128'(idx), 128'(11 + stalls));
                check("fin_valid", 128'(round_key_valid), 128'd0);
                check("fin_busy", 128'(busy), 128'd0);
                check("fin_round", 128'(round), 128'd10);
                check("fin_key", round_key, exp);
                finished = 1'b1;
                start = 1'b0;
            end else begin
                check("valid", 128'(round_key_valid), 128'd1);
                check("busy", 128'(busy), 128'd1);
                check("no_done", 128'(done), 128'd0);
                check("round", 128'(round), 128'(er));
                check(use_zero ? "zero_key" : "fips_key", round_key, exp);
                key_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                start     = inject && (er == 3 || er == 10);
                key_in    = 128'h0123456789abcdeffedcba9876543210;
                if (!key_ready) stalls++;
                else if (er < 10) er++;
                else fin_due = 1'b1;
                @(negedge clk);
                idx++;
            end
        end
        if (!finished) check("expand_timeout", 128'(idx), 128'd0);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        key_ready = 1'b0;
        key_in    = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", 128'(round_key_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_round", 128'(round), 128'd0);
        check("rst_key", round_key, 128'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        do_start(FIPS_KEY);
        expand(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("done_single", 128'(done), 128'd0);

        do_start(ZERO_KEY);
        expand(1'b1, 1'b0, 1'b0);
        @(negedge clk);

        do_start(FIPS_KEY);
        expand(1'b0, 1'b1, 1'b0);
        @(negedge clk);

        // Starts at round 3, round 10 and in FIN must be ignored; the one after FIN is taken.
        do_start(FIPS_KEY);
        expand(1'b0, 1'b0, 1'b1);
        start  = 1'b1;
        key_in = '1;
        @(negedge clk);
        check("fin_start_ignored", 128'(round_key_valid), 128'd0);
        check("done_single_inj", 128'(done), 128'd0);
        key_in = ZERO_KEY;
        @(negedge clk);
        start  = 1'b0;
        key_in = '1;
        expand(1'b1, 1'b0, 1'b0);
        @(negedge clk);

        key_ready = 1'b1;
        do_start(FIPS_KEY);
        repeat (4) @(negedge clk);
        check("pre_reset_round", 128'(round), 128'd4);
        check("pre_reset_key", round_key, fips_rk[4]);
        #2 rst = 1'b0;
        #1;
        check("async_valid", 128'(round_key_valid), 128'd0);
        check("async_busy", 128'(busy), 128'd0);
        check("async_round", 128'(round), 128'd0);
        check("async_key", round_key, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_valid", 128'(round_key_valid), 128'd0);
        check("idle_busy", 128'(busy), 128'd0);
        check("idle_done", 128'(done), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
